// File: rtl/result_streamer.sv
// Result streamer: waits for every core to report finish, reads the matrix header
// from data memory, then streams matrix C out one element at a time under ready/valid.
module result_streamer #(
   parameter int N_CORES = 8,
   parameter int AW      = 16,
   parameter int DW      = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N_CORES-1:0] finish,
   output logic               mem_rd,
   output logic [AW-1:0]      mem_addr,
   input  logic [DW-1:0]      mem_data,
   output logic [DW-1:0]      out_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic               out_eol,
   output logic               out_last,
   output logic               busy,
   output logic               done
);

   typedef enum logic [2:0] {
      IDLE,
      HDR,
      CALC,
      RD,
      CAP,
      OUT,
      DONE
   } state_t;

   state_t             state;
   logic [N_CORES-1:0] fin_seen;
   logic [1:0]         hdr_idx;
   logic [AW-1:0]      r1;
   logic [AW-1:0]      c1;
   logic [AW-1:0]      r2;
   logic [AW-1:0]      c2;
   logic [AW-1:0]      base;
   logic [AW-1:0]      count;
   logic [AW-1:0]      k;
   logic [AW-1:0]      col;

   logic               all_fin;
   logic [AW-1:0]      hdr_word;
   logic [AW-1:0]      calc_base;
   logic [AW-1:0]      calc_count;
   logic [AW-1:0]      next_k;

   // The arriving finish bits count in the same cycle they are latched.
   assign all_fin    = &(fin_seen | finish);
   assign hdr_word   = AW'(mem_data);

   // C2 is still on mem_data during CALC, so it feeds the arithmetic directly.
   assign calc_base  = AW'(4) + r1 * c1 + r2 * hdr_word;
   assign calc_count = r1 * hdr_word;
   assign next_k     = k + AW'(1);

   // NOTE: every state register is assigned with <= so all of them update from
   // the same pre-edge values; mixing in = here would create order-dependent logic.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         fin_seen  <= '0;
         hdr_idx   <= '0;
         r1        <= '0;
         c1        <= '0;
         r2        <= '0;
         c2        <= '0;
         base      <= '0;
         count     <= '0;
         k         <= '0;
         col       <= '0;
         mem_rd    <= 1'b0;
         mem_addr  <= '0;
         out_data  <= '0;
         out_valid <= 1'b0;
         out_eol   <= 1'b0;
         out_last  <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         fin_seen <= fin_seen | finish;

         case (state)
            IDLE: begin
               if (all_fin) begin
                  state    <= HDR;
                  busy     <= 1'b1;
                  mem_rd   <= 1'b1;
                  mem_addr <= AW'(1);
                  hdr_idx  <= '0;
               end
            end

            HDR: begin
               // Phase n carries the read of address n+1 and the data of address n.
               hdr_idx <= hdr_idx + 2'd1;
               case (hdr_idx)
                  2'd1:    r1 <= hdr_word;
                  2'd2:    c1 <= hdr_word;
                  2'd3:    r2 <= hdr_word;
                  default: ;
               endcase
               if (hdr_idx == 2'd3) begin
                  mem_rd <= 1'b0;
                  state  <= CALC;
               end else begin
                  mem_addr <= mem_addr + AW'(1);
               end
            end

            CALC: begin
               c2    <= hdr_word;
               base  <= calc_base;
               count <= calc_count;
               if (calc_count == '0) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end else begin
                  k        <= AW'(1);
                  col      <= AW'(1);
                  mem_rd   <= 1'b1;
                  mem_addr <= calc_base + AW'(1);
                  state    <= RD;
               end
            end

            RD: begin
               mem_rd <= 1'b0;
               state  <= CAP;
            end

            CAP: begin
               out_data  <= mem_data;
               out_valid <= 1'b1;
               out_eol   <= (col == c2);
               out_last  <= (k == count);
               state     <= OUT;
            end

            OUT: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  out_eol   <= 1'b0;
                  out_last  <= 1'b0;
                  if (k == count) begin
                     state <= DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end else begin
                     // col tracks the position within the row so eol needs no divider.
                     k        <= next_k;
                     col      <= (col == c2) ? AW'(1) : col + AW'(1);
                     mem_rd   <= 1'b1;
                     mem_addr <= base + next_k;
                     state    <= RD;
                  end
               end
            end

            DONE: ;

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_result_streamer.sv
// Self-checking bench for result_streamer: behavioural memory, scoreboard queues for
// expected read addresses and output elements, directed scenarios plus backpressure.
module tb_result_streamer;

   localparam int N_CORES = 8;
   localparam int AW      = 16;
   localparam int DW      = 16;

   logic               clk = 1'b0;
   logic               rst;
   logic [N_CORES-1:0] finish;
   logic               mem_rd;
   logic [AW-1:0]      mem_addr;
   logic [DW-1:0]      mem_data = '0;
   logic [DW-1:0]      out_data;
   logic               out_valid;
   logic               out_ready;
   logic               out_eol;
   logic               out_last;
   logic               busy;
   logic               done;

   always #5 clk = ~clk;

   result_streamer #(
      .N_CORES(N_CORES),
      .AW     (AW),
      .DW     (DW)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .finish   (finish),
      .mem_rd   (mem_rd),
      .mem_addr (mem_addr),
      .mem_data (mem_data),
      .out_data (out_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_eol  (out_eol),
      .out_last (out_last),
      .busy     (busy),
      .done     (done)
   );

   typedef struct packed {
      logic [DW-1:0] data;
      logic          eol;
      logic          last;
   } elem_t;

   logic [DW-1:0] mem [int];
   logic [AW-1:0] exp_addr [$];
   elem_t         exp_el [$];

   int            n_checks = 0;
   int            n_fail = 0;
   int            cyc = 0;
   int            n_out = 0;
   int            last_rd_cyc = -1;
   int            done_cyc = -1;
   bit            mon_on = 1'b0;
   bit            rand_ready = 1'b0;
   bit            saw_wrap = 1'b0;
   logic [AW-1:0] prev_rd_addr = '0;

   function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
      if (mem.exists(int'(a))) return mem[int'(a)];
      return DW'(a) ^ DW'(16'h5A5A);
   endfunction

   // Synchronous-read memory: data appears the cycle after mem_rd.
   always @(posedge clk) if (mem_rd) mem_data <= mem_word(mem_addr);

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // One clock: score the accept that the coming edge performs, then sample reads.
   task automatic tick();
      elem_t e;
      if (mon_on && out_valid && out_ready) begin
         n_out++;
         if (exp_el.size() == 0) begin
            check("out_unexpected", 32'(out_valid), 0);
         end else begin
            e = exp_el.pop_front();
            check("out_data", 32'(out_data), 32'(e.data));
            check("out_eol", 32'(out_eol), 32'(e.eol));
            check("out_last", 32'(out_last), 32'(e.last));
         end
      end
      @(negedge clk);
      cyc++;
      if (mon_on && mem_rd) begin
         if (exp_addr.size() == 0) check("rd_unexpected", 32'(mem_rd), 0);
         else check("rd_addr", 32'(mem_addr), 32'(exp_addr.pop_front()));
         if (prev_rd_addr == 16'hFFFF && mem_addr == '0) saw_wrap = 1'b1;
         prev_rd_addr = mem_addr;
         last_rd_cyc  = cyc;
      end
      if (done && done_cyc < 0) done_cyc = cyc;
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
   endtask

   // Builds memory contents and the expected read/output streams from the header.
   task automatic setup(input int r1, input int c1, input int r2, input int c2,
                        input int max_el, input bit seq);
      logic [AW-1:0] b;
      logic [AW-1:0] cnt;
      logic [AW-1:0] a;
      elem_t         e;
      int            n;
      mem.delete();
      exp_addr.delete();
      exp_el.delete();
      n_out        = 0;
      last_rd_cyc  = -1;
      done_cyc     = -1;
      saw_wrap     = 1'b0;
      prev_rd_addr = '0;
      mem[1] = DW'(r1);
      mem[2] = DW'(c1);
      mem[3] = DW'(r2);
      mem[4] = DW'(c2);
      for (int i = 1; i <= 4; i++) exp_addr.push_back(AW'(i));
      b   = AW'(4 + r1 * c1 + r2 * c2);
      cnt = AW'(r1 * c2);
      n   = (int'(cnt) < max_el) ? int'(cnt) : max_el;
      for (int k = 1; k <= n; k++) begin
         a = b + AW'(k);
         if (mem.exists(int'(a))) begin
            e.data = mem[int'(a)];
         end else begin
            e.data = seq ? DW'(k + 4) : DW'($urandom);
            mem[int'(a)] = e.data;
         end
         e.eol  = ((k % c2) == 0);
         e.last = (k == int'(cnt));
         exp_addr.push_back(a);
         exp_el.push_back(e);
      end
   endtask

   task automatic do_reset();
      mon_on     = 1'b0;
      rand_ready = 1'b0;
      rst        = 1'b1;
      finish     = '0;
      out_ready  = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic run_to_done(input string tag, input int budget);
      int n = 0;
      while (!done && n < budget) begin
         tick();
         n++;
      end
      check({tag, "_done"}, 32'(done), 1);
      check({tag, "_addr_left"}, 32'(exp_addr.size()), 0);
      check({tag, "_elem_left"}, 32'(exp_el.size()), 0);
      check({tag, "_busy"}, 32'(busy), 0);
   endtask

   initial begin
      int guard;
      int hdrs [4][4] = '{'{2, 5, 5, 3}, '{1, 1, 4, 4}, '{3, 2, 1, 1}, '{4, 4, 4, 4}};

      rst       = 1'b1;
      finish    = '0;
      out_ready = 1'b1;
      tick();
      tick();
      check("rst_mem_rd", 32'(mem_rd), 0);
      check("rst_mem_addr", 32'(mem_addr), 0);
      check("rst_out_data", 32'(out_data), 0);
      check("rst_out_valid", 32'(out_valid), 0);
      check("rst_out_eol", 32'(out_eol), 0);
      check("rst_out_last", 32'(out_last), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(done), 0);
      rst = 1'b0;
      tick();

      // Basic 2x2 result: reads 1..4, 17..20, outputs 5..8.
      setup(2, 3, 3, 2, 100, 1'b1);
      mon_on = 1'b1;
      finish = '1;
      run_to_done("basic", 200);
      check("basic_n_out", 32'(n_out), 4);
      finish = 8'h0F;
      repeat (5) begin
         tick();
         check("done_hold", 32'(done), 1);
         check("done_no_rd", 32'(mem_rd), 0);
      end

      // Finish bits one at a time; nothing may start until the last arrives.
      do_reset();
      setup(2, 3, 3, 2, 100, 1'b1);
      mon_on = 1'b1;
      for (int b = 0; b < N_CORES; b++) begin
         finish = N_CORES'(1) << b;
         tick();
         finish = '0;
         if (b == N_CORES - 1) begin
            check("hdr_start_rd", 32'(mem_rd), 1);
            check("hdr_start_addr", 32'(mem_addr), 1);
            check("hdr_start_busy", 32'(busy), 1);
         end else begin
            repeat (4) begin
               check("wait_no_rd", 32'(mem_rd), 0);
               tick();
            end
            check("wait_no_rd", 32'(mem_rd), 0);
         end
      end
      run_to_done("pulsed", 200);

      // Stall on element 2 for 10 cycles.
      do_reset();
      setup(2, 3, 3, 2, 100, 1'b1);
      mon_on = 1'b1;
      finish = '1;
      guard  = 0;
      while (!(out_valid && n_out == 1) && guard < 200) begin
         tick();
         guard++;
      end
      check("stall_reached", 32'(out_valid), 1);
      out_ready = 1'b0;
      repeat (10) begin
         tick();
         check("stall_valid", 32'(out_valid), 1);
         check("stall_data", 32'(out_data), 6);
         check("stall_eol", 32'(out_eol), 1);
         check("stall_no_rd", 32'(mem_rd), 0);
      end
      out_ready = 1'b1;
      run_to_done("stall", 200);
      check("stall_n_out", 32'(n_out), 4);

      // Empty result: header reads only, done two cycles after the last read.
      do_reset();
      setup(0, 5, 3, 7, 100, 1'b0);
      mon_on = 1'b1;
      finish = '1;
      run_to_done("empty", 100);
      check("empty_done_lat", 32'(done_cyc - last_rd_cyc), 2);
      check("empty_n_out", 32'(n_out), 0);

      // Assorted shapes under random backpressure.
      for (int t = 0; t < 4; t++) begin
         do_reset();
         setup(hdrs[t][0], hdrs[t][1], hdrs[t][2], hdrs[t][3], 100, 1'b0);
         mon_on     = 1'b1;
         rand_ready = 1'b1;
         finish     = '1;
         run_to_done("shape", 1000);
         check("shape_n_out", 32'(n_out), 32'(hdrs[t][0] * hdrs[t][3]));
         rand_ready = 1'b0;
      end

      // Reset while element 3 is presented, then a clean replay.
      do_reset();
      setup(2, 3, 3, 2, 100, 1'b1);
      mon_on = 1'b1;
      finish = '1;
      guard  = 0;
      while (!(out_valid && n_out == 2) && guard < 200) begin
         tick();
         guard++;
      end
      check("abort_reached", 32'(out_valid), 1);
      out_ready = 1'b0;
      tick();
      mon_on = 1'b0;
      rst    = 1'b1;
      finish = '0;
      #1;
      check("abort_valid", 32'(out_valid), 0);
      check("abort_data", 32'(out_data), 0);
      check("abort_eol", 32'(out_eol), 0);
      check("abort_last", 32'(out_last), 0);
      check("abort_rd", 32'(mem_rd), 0);
      check("abort_addr", 32'(mem_addr), 0);
      check("abort_busy", 32'(busy), 0);
      check("abort_done", 32'(done), 0);
      tick();
      rst       = 1'b0;
      out_ready = 1'b1;
      repeat (5) begin
         tick();
         check("abort_wait_rd", 32'(mem_rd), 0);
         check("abort_wait_busy", 32'(busy), 0);
      end
      setup(2, 3, 3, 2, 100, 1'b1);
      mon_on = 1'b1;
      finish = '1;
      run_to_done("replay", 200);
      check("replay_n_out", 32'(n_out), 4);

      // Wrapping header arithmetic and address roll-over past 0xFFFF.
      do_reset();
      setup(255, 255, 255, 255, 1100, 1'b0);
      mon_on = 1'b1;
      finish = '1;
      guard  = 0;
      while (exp_addr.size() != 0 && guard < 8000) begin
         tick();
         guard++;
      end
      check("wrap_addr_left", 32'(exp_addr.size()), 0);
      check("wrap_seen", 32'(saw_wrap), 1);
      check("wrap_busy", 32'(busy), 1);
      do_reset();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
